// File: rtl/ssd_time_decoder_pkg.sv
`default_nettype none
// Shared timer definitions: seven-segment codes ({g,f,e,d,c,b,a}, active-high),
// tracker state encoding and the BCD-to-seconds helper.
package ssd_time_decoder_pkg;

  localparam logic [6:0] SEG_ZERO  = 7'h3F;
  localparam logic [6:0] SEG_ONE   = 7'h06;
  localparam logic [6:0] SEG_TWO   = 7'h5B;
  localparam logic [6:0] SEG_THREE = 7'h4F;
  localparam logic [6:0] SEG_FOUR  = 7'h66;
  localparam logic [6:0] SEG_FIVE  = 7'h6D;
  localparam logic [6:0] SEG_SIX   = 7'h7D;
  localparam logic [6:0] SEG_SEVEN = 7'h07;
  localparam logic [6:0] SEG_EIGHT = 7'h7F;
  localparam logic [6:0] SEG_NINE  = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [11:0] SECS_MAX = 12'd3599;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } state_e;

  // Only meaningful for a valid frame; out-of-range digits simply wrap.
  function automatic logic [11:0] bcd_to_secs(input logic [15:0] bcd);
    logic [11:0] mins;
    mins = 12'(bcd[15:12]) * 12'd10 + 12'(bcd[11:8]);
    return mins * 12'd60 + 12'(bcd[7:4]) * 12'd10 + 12'(bcd[3:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_digit_decode.sv
`default_nettype none
// ssd_digit_decode: combinational map of one seven-segment code to a BCD digit
// plus a legality flag.
module ssd_digit_decode
  import ssd_time_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    bcd_o   = 4'd0;
    case (seg_i)
      SEG_ZERO:  bcd_o = 4'd0;
      SEG_ONE:   bcd_o = 4'd1;
      SEG_TWO:   bcd_o = 4'd2;
      SEG_THREE: bcd_o = 4'd3;
      SEG_FOUR:  bcd_o = 4'd4;
      SEG_FIVE:  bcd_o = 4'd5;
      SEG_SIX:   bcd_o = 4'd6;
      SEG_SEVEN: bcd_o = 4'd7;
      SEG_EIGHT: bcd_o = 4'd8;
      SEG_NINE:  bcd_o = 4'd9;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd_time_decoder.sv
`default_nettype none
// ssd_time_decoder: monitors the mm:ss seven-segment digit codes, decodes them to
// BCD and binary seconds, and flags any change that is not a legal +1 s step.
module ssd_time_decoder
  import ssd_time_decoder_pkg::*;
#(
  parameter int unsigned BLANK_TOL = 4,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ssd_min_h_in,
  input  logic [6:0]       ssd_min_l_in,
  input  logic [6:0]       ssd_sec_h_in,
  input  logic [6:0]       ssd_sec_l_in,
  input  logic             clr_err,
  output logic [15:0]      bcd_time,
  output logic [11:0]      time_sec,
  output logic             time_vld,
  output logic             tick,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_TOL - 1);

  // Digit index 3 = min_h, 2 = min_l, 1 = sec_h, 0 = sec_l.
  logic [3:0][6:0] seg_q;
  logic [3:0]      dig_vld;
  logic [3:0][3:0] dig_bcd;

  logic            frame_valid;
  logic [11:0]     frame_secs;
  logic [11:0]     next_secs;

  state_e          state_q, state_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [11:0]     secs_q, secs_d;
  logic            tick_q, tick_d;
  logic            mis_q, mis_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]      blank_q, blank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
    end else begin
      seg_q <= {ssd_min_h_in, ssd_min_l_in, ssd_sec_h_in, ssd_sec_l_in};
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_digit
    ssd_digit_decode u_dec (
      .seg_i   (seg_q[i]),
      .valid_o (dig_vld[i]),
      .bcd_o   (dig_bcd[i])
    );
  end

  assign frame_valid = (&dig_vld) && (dig_bcd[3] <= 4'd5) && (dig_bcd[1] <= 4'd5);
  assign frame_secs  = bcd_to_secs(dig_bcd);
  assign next_secs   = (secs_q == SECS_MAX) ? 12'd0 : secs_q + 12'd1;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    secs_d  = secs_q;
    tick_d  = 1'b0;
    mis_d   = 1'b0;
    blank_d = blank_q;
    case (state_q)
      ST_SEARCH: begin
        if (frame_valid) begin
          state_d = ST_TRACK;
          bcd_d   = dig_bcd;
          secs_d  = frame_secs;
          blank_d = 4'd0;
        end
      end
      ST_TRACK: begin
        if (frame_valid) begin
          blank_d = 4'd0;
          bcd_d   = dig_bcd;
          secs_d  = frame_secs;
          if (frame_secs == secs_q) begin
            tick_d = 1'b0;
          end else if (frame_secs == next_secs) begin
            tick_d = 1'b1;
          end else begin
            mis_d = 1'b1;
          end
        end else if (blank_q >= BLANK_LAST) begin
          // Display considered lost; keep the last time for inspection.
          state_d = ST_SEARCH;
          blank_d = 4'd0;
        end else begin
          blank_d = blank_q + 4'd1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (clr_err) begin
      err_d = '0;
    end else if (mis_d && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      bcd_q   <= '0;
      secs_q  <= '0;
      tick_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      secs_q  <= secs_d;
      tick_q  <= tick_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  assign bcd_time = bcd_q;
  assign time_sec = secs_q;
  assign time_vld = (state_q == ST_TRACK);
  assign tick     = tick_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_time_decoder.sv
`default_nettype none
// Self-checking bench for ssd_time_decoder: directed scenarios plus randomized
// frames checked against a seconds-level reference model.
module tb_ssd_time_decoder;

  localparam int BLANK_TOL = 4;
  localparam int ERR_W     = 8;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       mh, ml, sh, sl;
  logic             clr;
  logic [15:0]      bcd_time;
  logic [11:0]      time_sec;
  logic             time_vld, tick, mismatch;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  ssd_time_decoder #(.BLANK_TOL(BLANK_TOL), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ssd_min_h_in (mh),
    .ssd_min_l_in (ml),
    .ssd_sec_h_in (sh),
    .ssd_sec_l_in (sl),
    .clr_err      (clr),
    .bcd_time     (bcd_time),
    .time_sec     (time_sec),
    .time_vld     (time_vld),
    .tick         (tick),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: frame captured one edge ago, plus lock/held-time state.
  logic [6:0] p1 [4];
  bit m_lock, m_tick, m_mis;
  int m_held, m_blank, m_err;

  function automatic int dig(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [15:0] secs2bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_reset();
    m_lock = 0; m_tick = 0; m_mis = 0;
    m_held = 0; m_blank = 0; m_err = 0;
    p1 = '{default: 7'h00};
  endtask

  task automatic model_step(input bit c);
    int d[4];
    int s;
    bit v;
    for (int i = 0; i < 4; i++) d[i] = dig(p1[i]);
    v = d[0] >= 0 && d[1] >= 0 && d[2] >= 0 && d[3] >= 0 && d[0] <= 5 && d[2] <= 5;
    m_tick = 0;
    m_mis  = 0;
    if (v) begin
      s = (10 * d[0] + d[1]) * 60 + 10 * d[2] + d[3];
      m_blank = 0;
      if (!m_lock) begin
        m_lock = 1;
        m_held = s;
      end else if (s == (m_held + 1) % 3600) begin
        m_tick = 1;
        m_held = s;
      end else if (s != m_held) begin
        m_mis  = 1;
        m_held = s;
      end
    end else if (m_lock) begin
      m_blank++;
      if (m_blank >= BLANK_TOL) begin
        m_lock  = 0;
        m_blank = 0;
      end
    end
    if (c) m_err = 0;
    else if (m_mis && m_err < ERR_MAX) m_err++;
  endtask

  task automatic cycle();
    bit c;
    c = clr;
    @(posedge clk);
    model_step(c);
    p1 = '{mh, ml, sh, sl};
    #1;
  endtask

  task automatic drive_time(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    mh = seg_tab[m / 10];
    ml = seg_tab[m % 10];
    sh = seg_tab[x / 10];
    sl = seg_tab[x % 10];
  endtask

  task automatic drive_blank();
    mh = 7'h00; ml = 7'h00; sh = 7'h00; sl = 7'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    drive_blank();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    drive_blank();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if ({bcd_time, time_sec, time_vld, tick, mismatch, err_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got bcd=%h sec=%0d vld=%b tick=%b mis=%b err=%0d want all 0",
               bcd_time, time_sec, time_vld, tick, mismatch, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    drive_time(754);
    cycle();
    tests++;
    if (time_vld !== 1'b0) begin fails++; $display("FAIL capture_latency: vld got %b want 0", time_vld); end
    cycle();
    tests++;
    if (time_vld !== 1'b1) begin fails++; $display("FAIL capture_vld: got %b want 1", time_vld); end
    tests++;
    if (bcd_time !== 16'h1234) begin fails++; $display("FAIL capture_bcd: got %h want 1234", bcd_time); end
    tests++;
    if (time_sec !== 12'd754) begin fails++; $display("FAIL capture_sec: got %0d want 754", time_sec); end
    tests++;
    if ({tick, mismatch} !== 2'b00) begin fails++; $display("FAIL capture_pulses: got %b want 00", {tick, mismatch}); end
  endtask

  task automatic test_tick();
    drive_time(755);
    cycle();
    tests++;
    if (tick !== 1'b0) begin fails++; $display("FAIL tick_early: got %b want 0", tick); end
    cycle();
    tests++;
    if (tick !== 1'b1 || mismatch !== 1'b0) begin
      fails++; $display("FAIL tick_pulse: got tick=%b mis=%b want 1 0", tick, mismatch);
    end
    tests++;
    if (time_sec !== 12'd755 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL tick_value: got sec=%0d err=%0d want 755 0", time_sec, err_cnt);
    end
    cycle();
    tests++;
    if (tick !== 1'b0) begin fails++; $display("FAIL tick_single: got %b want 0", tick); end
  endtask

  task automatic test_mismatch();
    drive_time(760);
    cycle(); cycle();
    tests++;
    if (mismatch !== 1'b1 || tick !== 1'b0) begin
      fails++; $display("FAIL jump_pulse: got mis=%b tick=%b want 1 0", mismatch, tick);
    end
    tests++;
    if (err_cnt !== 8'd1 || time_sec !== 12'd760) begin
      fails++; $display("FAIL jump_value: got err=%0d sec=%0d want 1 760", err_cnt, time_sec);
    end
    drive_time(1200);
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    tests++;
    if (mismatch !== 1'b1 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL clr_wins: got mis=%b err=%0d want 1 0", mismatch, err_cnt);
    end
    tests++;
    if (bcd_time !== 16'h2000) begin fails++; $display("FAIL clr_jump_bcd: got %h want 2000", bcd_time); end
  endtask

  task automatic test_wrap();
    drive_time(3599);
    cycle(); cycle();
    drive_time(0);
    cycle(); cycle();
    tests++;
    if (tick !== 1'b1 || mismatch !== 1'b0) begin
      fails++; $display("FAIL wrap_pulse: got tick=%b mis=%b want 1 0", tick, mismatch);
    end
    tests++;
    if (time_sec !== 12'd0 || bcd_time !== 16'h0000) begin
      fails++; $display("FAIL wrap_value: got sec=%0d bcd=%h want 0 0000", time_sec, bcd_time);
    end
    tests++;
    if (err_cnt !== 8'd1) begin fails++; $display("FAIL wrap_err: got %0d want 1", err_cnt); end
  endtask

  task automatic test_blank();
    drive_time(428);
    cycle(); cycle();
    drive_blank();
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (time_vld !== 1'b1) begin fails++; $display("FAIL blank3_vld[%0d]: got %b want 1", i, time_vld); end
    end
    drive_time(428);
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (time_vld !== 1'b1) begin fails++; $display("FAIL blank_restore_vld[%0d]: got %b want 1", i, time_vld); end
    end
    drive_blank();
    for (int i = 0; i < 4; i++) cycle();
    tests++;
    if (time_vld !== 1'b1) begin fails++; $display("FAIL blank_tol_minus1: got %b want 1", time_vld); end
    cycle();
    tests++;
    if (time_vld !== 1'b0) begin fails++; $display("FAIL blank_drop_vld: got %b want 0", time_vld); end
    tests++;
    if (bcd_time !== 16'h0708 || time_sec !== 12'd428) begin
      fails++; $display("FAIL blank_hold: got bcd=%h sec=%0d want 0708 428", bcd_time, time_sec);
    end
    drive_time(429);
    cycle(); cycle();
    tests++;
    if (time_vld !== 1'b1 || time_sec !== 12'd429 || {tick, mismatch} !== 2'b00) begin
      fails++; $display("FAIL relock: got vld=%b sec=%0d tick=%b mis=%b want 1 429 0 0",
                        time_vld, time_sec, tick, mismatch);
    end
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_time((i % 2 == 0) ? 10 : 30);
      cycle();
    end
    tests++;
    if (err_cnt !== 8'hFF || mismatch !== 1'b1) begin
      fails++; $display("FAIL err_saturate: got err=%0d mis=%b want 255 1", err_cnt, mismatch);
    end
  endtask

  task automatic test_random();
    int cur, r, blank_left;
    cur = 30;
    blank_left = 0;
    drive_time(cur);
    for (int n = 0; n < 800; n++) begin
      if (blank_left > 0) begin
        drive_blank();
        blank_left--;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55) begin
          cur = (cur + 1) % 3600;
          drive_time(cur);
        end else if (r < 65) begin
          drive_time(cur);
        end else if (r < 77) begin
          cur = $urandom_range(0, 3599);
          drive_time(cur);
        end else if (r < 88) begin
          drive_blank();
          blank_left = $urandom_range(0, 5);
        end else if (r < 94) begin
          drive_time(cur);
          mh = seg_tab[$urandom_range(6, 9)];
        end else begin
          mh = 7'($urandom_range(0, 127));
          ml = 7'($urandom_range(0, 127));
          sh = 7'($urandom_range(0, 127));
          sl = 7'($urandom_range(0, 127));
        end
      end
      clr = ($urandom_range(0, 24) == 0);
      cycle();
      tests++;
      if (time_vld !== m_lock || tick !== m_tick || mismatch !== m_mis) begin
        fails++; $display("FAIL rand_flags[%0d]: got vld=%b tick=%b mis=%b want %b %b %b",
                          n, time_vld, tick, mismatch, m_lock, m_tick, m_mis);
      end
      tests++;
      if (time_sec !== 12'(m_held) || bcd_time !== secs2bcd(m_held)) begin
        fails++; $display("FAIL rand_time[%0d]: got sec=%0d bcd=%h want %0d %h",
                          n, time_sec, bcd_time, m_held, secs2bcd(m_held));
      end
      tests++;
      if (err_cnt !== 8'(m_err)) begin
        fails++; $display("FAIL rand_err[%0d]: got %0d want %0d", n, err_cnt, m_err);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_time(10); cycle();
    drive_time(20); cycle();
    drive_time(30); cycle();
    drive_time(40); cycle();
    cycle(); cycle();
    tests++;
    if (err_cnt !== 8'd3 || time_vld !== 1'b1) begin
      fails++; $display("FAIL async_pre: got err=%0d vld=%b want 3 1", err_cnt, time_vld);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({bcd_time, time_sec, time_vld, tick, mismatch, err_cnt} !== '0) begin
      fails++; $display("FAIL async_reset: got bcd=%h sec=%0d vld=%b tick=%b mis=%b err=%0d want all 0",
                        bcd_time, time_sec, time_vld, tick, mismatch, err_cnt);
    end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr = 1'b0;
    drive_blank();
    test_reset();
    test_capture();
    test_tick();
    test_mismatch();
    test_wrap();
    test_blank();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
